// File: rtl/load_interlock_ctrl.sv
// Load-use interlock and ALU operand forwarding control beside the ID stage.
// Tracks EX/MEM register writes in shadow state; outputs are combinational from that state and the ID inputs.
module load_interlock_ctrl #(
  parameter int REG_BITS = 5,
  parameter int CNT_BITS = 16
) (
  input  logic                clk,
  input  logic                clrn,
  input  logic                id_valid,
  input  logic [REG_BITS-1:0] id_rs,
  input  logic [REG_BITS-1:0] id_rt,
  input  logic                id_use_rs,
  input  logic                id_use_rt,
  input  logic                id_wreg,
  input  logic                id_m2reg,
  input  logic [REG_BITS-1:0] id_rn,
  input  logic                mem_wait,
  output logic                LOADDEPEEN,
  output logic                bubble,
  output logic [1:0]          fwda,
  output logic [1:0]          fwdb,
  output logic [CNT_BITS-1:0] stall_cnt
);

  logic                ex_wreg, ex_m2reg, mem_wreg, mem_m2reg;
  logic [REG_BITS-1:0] ex_rn, mem_rn;
  logic                ex_hit_s, ex_hit_t, mem_hit_s, mem_hit_t, lu_hazard;

  function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] c);
    if (&c) return c;
    return c + 1'b1;
  endfunction

  // EX beats MEM; a pending load in EX yields 00 because it always stalls.
  function automatic logic [1:0] fwd_sel(input logic ex_hit, input logic mem_hit,
                                         input logic ex_ld, input logic mem_ld);
    if (ex_hit && !ex_ld)       return 2'b01;
    else if (ex_hit)            return 2'b00;
    else if (mem_hit && !mem_ld) return 2'b10;
    else if (mem_hit)           return 2'b11;
    return 2'b00;
  endfunction

  always_comb begin
    ex_hit_s  = ex_wreg  && (ex_rn  != '0) && (ex_rn  == id_rs);
    ex_hit_t  = ex_wreg  && (ex_rn  != '0) && (ex_rn  == id_rt);
    mem_hit_s = mem_wreg && (mem_rn != '0) && (mem_rn == id_rs);
    mem_hit_t = mem_wreg && (mem_rn != '0) && (mem_rn == id_rt);
    lu_hazard = id_valid && ex_m2reg &&
                ((id_use_rs && ex_hit_s) || (id_use_rt && ex_hit_t));
  end

  // Gated by clrn so reset forces the idle values even with mem_wait asserted.
  always_comb begin
    LOADDEPEEN = 1'b1;
    bubble     = 1'b0;
    fwda       = 2'b00;
    fwdb       = 2'b00;
    if (clrn) begin
      fwda = fwd_sel(ex_hit_s, mem_hit_s, ex_m2reg, mem_m2reg);
      fwdb = fwd_sel(ex_hit_t, mem_hit_t, ex_m2reg, mem_m2reg);
      if (mem_wait) begin
        LOADDEPEEN = 1'b0;
      end else if (lu_hazard) begin
        LOADDEPEEN = 1'b0;
        bubble     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      ex_wreg   <= 1'b0;
      ex_m2reg  <= 1'b0;
      ex_rn     <= '0;
      mem_wreg  <= 1'b0;
      mem_m2reg <= 1'b0;
      mem_rn    <= '0;
      stall_cnt <= '0;
    end else if (!mem_wait) begin
      mem_wreg  <= ex_wreg;
      mem_m2reg <= ex_m2reg;
      mem_rn    <= ex_rn;
      if (bubble) begin
        ex_wreg   <= 1'b0;
        ex_m2reg  <= 1'b0;
        ex_rn     <= '0;
        stall_cnt <= sat_inc(stall_cnt);
      end else begin
        ex_wreg   <= id_wreg && id_valid;
        ex_m2reg  <= id_m2reg && id_valid;
        ex_rn     <= id_rn;
      end
    end
  end

endmodule

// File: tb/tb_load_interlock_ctrl.sv
// Scoreboard bench for load_interlock_ctrl: driver queues expected outputs per cycle,
// a negedge monitor pops and compares them against the DUT.
module tb_load_interlock_ctrl;

  localparam int RB = 5;
  localparam int CB = 4;

  logic          clk = 1'b0;
  logic          clrn;
  logic          id_valid, id_use_rs, id_use_rt, id_wreg, id_m2reg, mem_wait;
  logic [RB-1:0] id_rs, id_rt, id_rn;
  logic          LOADDEPEEN, bubble;
  logic [1:0]    fwda, fwdb;
  logic [CB-1:0] stall_cnt;

  logic [9:0] exp_q[$];
  string      name_q[$];
  int         checks = 0;
  int         failures = 0;

  load_interlock_ctrl #(.REG_BITS(RB), .CNT_BITS(CB)) dut (
    .clk(clk), .clrn(clrn), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wreg(id_wreg),
    .id_m2reg(id_m2reg), .id_rn(id_rn), .mem_wait(mem_wait),
    .LOADDEPEEN(LOADDEPEEN), .bubble(bubble), .fwda(fwda), .fwdb(fwdb),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] E(input logic ld, input logic bub, input logic [1:0] fa,
                                   input logic [1:0] fb, input logic [CB-1:0] cnt);
    return {ld, bub, fa, fb, cnt};
  endfunction

  task automatic step(input logic rst_n, input logic v, input logic [RB-1:0] rs,
                      input logic [RB-1:0] rt, input logic urs, input logic urt,
                      input logic wr, input logic m2, input logic [RB-1:0] rn,
                      input logic mw, input logic [9:0] exp_v, input string nm);
    @(posedge clk);
    #1;
    clrn = rst_n; id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs;
    id_use_rt = urt; id_wreg = wr; id_m2reg = m2; id_rn = rn; mem_wait = mw;
    exp_q.push_back(exp_v);
    name_q.push_back(nm);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [9:0] e, a;
      string      n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      a = {LOADDEPEEN, bubble, fwda, fwdb, stall_cnt};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL %s: got ld=%b bub=%b fwda=%b fwdb=%b cnt=%0d, want ld=%b bub=%b fwda=%b fwdb=%b cnt=%0d",
                 n, a[9], a[8], a[7:6], a[5:4], a[3:0], e[9], e[8], e[7:6], e[5:4], e[3:0]);
      end
    end
  end

  initial begin
    logic [CB-1:0] cnt;
    clrn = 1'b0; id_valid = 0; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
    id_wreg = 0; id_m2reg = 0; id_rn = 0; mem_wait = 0;

    // reset with random inputs, including mem_wait and a load matching rs
    step(0, 1, 5'd5, 5'($urandom), 1, 1, 1, 1, 5'd5, 1, E(1,0,2'b00,2'b00,0), "reset_a");
    step(0, 1'($urandom), 5'($urandom), 5'($urandom), 1, 1, 1, 1, 5'($urandom), 1'($urandom),
         E(1,0,2'b00,2'b00,0), "reset_b");
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, E(1,0,2'b00,2'b00,0), "post_reset");

    // lw r5 ; add r6,r5,r7
    step(1, 1, 5'd1, 5'd0, 1, 0, 1, 1, 5'd5, 0, E(1,0,2'b00,2'b00,0), "lw_r5");
    step(1, 1, 5'd5, 5'd7, 1, 1, 1, 0, 5'd6, 0, E(0,1,2'b00,2'b00,0), "lu_stall");
    step(1, 1, 5'd5, 5'd7, 1, 1, 1, 0, 5'd6, 0, E(1,0,2'b11,2'b00,1), "lu_fwd11");

    // add r3 ; sub r4,r3,r3 ; or r8,r3,r9
    step(1, 1, 5'd1, 5'd2, 1, 1, 1, 0, 5'd3, 0, E(1,0,2'b00,2'b00,1), "add_r3");
    step(1, 1, 5'd3, 5'd3, 1, 1, 1, 0, 5'd4, 0, E(1,0,2'b01,2'b01,1), "fwd_ex");
    step(1, 1, 5'd3, 5'd9, 1, 1, 1, 0, 5'd8, 0, E(1,0,2'b10,2'b00,1), "fwd_mem");

    // lw r0 then use of r0; lw r5 then rs=5 not read
    step(1, 1, 5'd1, 5'd0, 1, 0, 1, 1, 5'd0, 0, E(1,0,2'b00,2'b00,1), "lw_r0");
    step(1, 1, 5'd0, 5'd0, 1, 1, 1, 0, 5'd10, 0, E(1,0,2'b00,2'b00,1), "use_r0");
    step(1, 1, 5'd1, 5'd0, 1, 0, 1, 1, 5'd5, 0, E(1,0,2'b00,2'b00,1), "lw_r5_b");
    step(1, 1, 5'd5, 5'd2, 0, 1, 1, 0, 5'd11, 0, E(1,0,2'b00,2'b00,1), "no_use_rs");

    // hazard held under mem_wait for 3 cycles, then exactly one bubble
    step(1, 1, 5'd1, 5'd0, 1, 0, 1, 1, 5'd12, 0, E(1,0,2'b00,2'b00,1), "lw_r12");
    for (int i = 0; i < 3; i++)
      step(1, 1, 5'd12, 5'd12, 1, 1, 1, 0, 5'd13, 1, E(0,0,2'b00,2'b00,1), "memwait_hold");
    step(1, 1, 5'd12, 5'd12, 1, 1, 1, 0, 5'd13, 0, E(0,1,2'b00,2'b00,1), "memwait_release");
    step(1, 1, 5'd12, 5'd12, 1, 1, 1, 0, 5'd13, 0, E(1,0,2'b11,2'b11,2), "after_bubble");

    // 20 load-use pairs drive the 4-bit counter into saturation
    cnt = 4'd2;
    for (int k = 0; k < 20; k++) begin
      step(1, 1, 5'd1, 5'd0, 1, 0, 1, 1, 5'd5, 0, E(1,0,2'b00,2'b00,cnt), "sat_lw");
      step(1, 1, 5'd5, 5'd7, 1, 1, 1, 0, 5'd6, 0, E(0,1,2'b00,2'b00,cnt), "sat_stall");
      cnt = (cnt == 4'd15) ? 4'd15 : cnt + 4'd1;
      step(1, 1, 5'd5, 5'd7, 1, 1, 1, 0, 5'd6, 0, E(1,0,2'b11,2'b00,cnt), "sat_fwd");
    end

    // reset pulse in the middle of a stall
    step(1, 1, 5'd1, 5'd0, 1, 0, 1, 1, 5'd5, 0, E(1,0,2'b00,2'b00,15), "mid_lw");
    step(1, 1, 5'd5, 5'd7, 1, 1, 1, 0, 5'd6, 0, E(0,1,2'b00,2'b00,15), "mid_stall");
    step(0, 1, 5'd5, 5'd7, 1, 1, 1, 0, 5'd6, 0, E(1,0,2'b00,2'b00,0), "mid_reset");
    step(1, 1, 5'd5, 5'd7, 1, 1, 1, 0, 5'd6, 0, E(1,0,2'b00,2'b00,0), "no_pending_stall");

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
